matrix_stream_multiplier: RTL and testbench

MATRIX_STREAM_MULTIPLIER -- requirements
Module: matrix_stream_multiplier

---
 rtl/matrix_stream_multiplier_if.sv | 26 ++
 rtl/matrix_stream_multiplier.sv | 164 ++++++++++++++++
 tb/tb_matrix_stream_multiplier.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_stream_multiplier_if.sv
// Load-beat and result-stream bundle for matrix_stream_multiplier.
interface matrix_stream_multiplier_if #(
    parameter int N      = 2,
    parameter int DATA_W = 8
);
    localparam int ACC_W = 2*DATA_W + $clog2(N);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_last;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/matrix_stream_multiplier.sv
// Streaming N x N multiplier: loads A/B row-major, then emits C = A x B
// row-major, one MAC per cycle, one result element per N+1 cycles.
module matrix_stream_multiplier #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int SIGNED = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic abort,
    output logic busy,
    matrix_stream_multiplier_if.slave bus
);
    localparam int ACC_W = 2*DATA_W + $clog2(N);
    localparam int NN    = N*N;
    localparam int IDX_W = $clog2(NN);
    localparam int KW    = $clog2(N);

    typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q [NN];
    logic [DATA_W-1:0] a_d [NN];
    logic [DATA_W-1:0] b_q [NN];
    logic [DATA_W-1:0] b_d [NN];
    logic [IDX_W-1:0]  beat_q, beat_d;
    logic [KW-1:0]     i_q, i_d;
    logic [KW-1:0]     j_q, j_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic [IDX_W-1:0]  a_idx, b_idx;
    logic [ACC_W-1:0]  a_ext, b_ext, prod, sum;
    logic              last_elem;

    // Extension to ACC_W makes the truncated product exact in both modes.
    function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
        ext = {{(ACC_W-DATA_W){(SIGNED != 0) & v[DATA_W-1]}}, v};
    endfunction

    always_comb begin
        a_idx     = IDX_W'(i_q) * IDX_W'(N) + IDX_W'(k_q);
        b_idx     = IDX_W'(k_q) * IDX_W'(N) + IDX_W'(j_q);
        a_ext     = ext(a_q[a_idx]);
        b_ext     = ext(b_q[b_idx]);
        prod      = a_ext * b_ext;
        sum       = acc_q + prod;
        last_elem = (i_q == KW'(N-1)) && (j_q == KW'(N-1));
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        beat_d      = beat_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (abort) begin
            state_d     = LOAD;
            beat_d      = '0;
            i_d         = '0;
            j_d         = '0;
            k_d         = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (bus.in_valid) begin
                        a_d[beat_q] = bus.in_a;
                        b_d[beat_q] = bus.in_b;
                        if (beat_q == IDX_W'(NN-1)) begin
                            beat_d  = '0;
                            i_d     = '0;
                            j_d     = '0;
                            k_d     = '0;
                            acc_d   = '0;
                            state_d = COMPUTE;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                    if (k_q == KW'(N-1)) begin
                        k_d         = '0;
                        out_data_d  = sum;
                        out_valid_d = 1'b1;
                        out_last_d  = last_elem;
                        state_d     = OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        acc_d       = '0;
                        k_d         = '0;
                        if (last_elem) begin
                            i_d     = '0;
                            j_d     = '0;
                            beat_d  = '0;
                            state_d = LOAD;
                        end else begin
                            state_d = COMPUTE;
                            if (j_q == KW'(N-1)) begin
                                j_d = '0;
                                i_d = i_q + 1'b1;
                            end else begin
                                j_d = j_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            beat_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            beat_q      <= beat_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign busy          = (state_q != LOAD);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_matrix_stream_multiplier.sv
// Bench for matrix_stream_multiplier: three configurations driven from
// directed and random matrices, checked against a plain-arithmetic model.
module tb_matrix_stream_multiplier;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vld = 1'b0;
    logic       abt = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] da  = '0;
    logic [7:0] db  = '0;
    int         sel = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic       busy0, busy1, busy2;

    always #5 clk = ~clk;

    matrix_stream_multiplier_if #(.N(2), .DATA_W(8)) if0 ();
    matrix_stream_multiplier_if #(.N(2), .DATA_W(8)) if1 ();
    matrix_stream_multiplier_if #(.N(4), .DATA_W(8)) if2 ();

    assign if0.in_valid  = vld && (sel == 0);
    assign if1.in_valid  = vld && (sel == 1);
    assign if2.in_valid  = vld && (sel == 2);
    assign if0.out_ready = rdy && (sel == 0);
    assign if1.out_ready = rdy && (sel == 1);
    assign if2.out_ready = rdy && (sel == 2);
    assign if0.in_a = da;
    assign if1.in_a = da;
    assign if2.in_a = da;
    assign if0.in_b = db;
    assign if1.in_b = db;
    assign if2.in_b = db;

    matrix_stream_multiplier #(.N(2), .DATA_W(8), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .abort(abt && (sel == 0)),
        .busy(busy0), .bus(if0)
    );
    matrix_stream_multiplier #(.N(2), .DATA_W(8), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .abort(abt && (sel == 1)),
        .busy(busy1), .bus(if1)
    );
    matrix_stream_multiplier #(.N(4), .DATA_W(8), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .abort(abt && (sel == 2)),
        .busy(busy2), .bus(if2)
    );

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint get_od(input int s);
        case (s)
            0:       return longint'(if0.out_data);
            1:       return longint'($signed(if1.out_data));
            default: return longint'(if2.out_data);
        endcase
    endfunction

    function automatic int get_ov(input int s);
        case (s)
            0:       return int'(if0.out_valid);
            1:       return int'(if1.out_valid);
            default: return int'(if2.out_valid);
        endcase
    endfunction

    function automatic int get_ol(input int s);
        case (s)
            0:       return int'(if0.out_last);
            1:       return int'(if1.out_last);
            default: return int'(if2.out_last);
        endcase
    endfunction

    function automatic int get_ir(input int s);
        case (s)
            0:       return int'(if0.in_ready);
            1:       return int'(if1.in_ready);
            default: return int'(if2.in_ready);
        endcase
    endfunction

    function automatic int get_busy(input int s);
        case (s)
            0:       return int'(busy0);
            1:       return int'(busy1);
            default: return int'(busy2);
        endcase
    endfunction

    function automatic int elem(input int v, input bit sg);
        logic [7:0] b8;
        b8 = 8'(v);
        return sg ? int'($signed(b8)) : int'(b8);
    endfunction

    function automatic void ref_mul(input int n, input bit sg,
                                    input int a[64], input int b[64],
                                    output longint q[$]);
        longint s;
        q = {};
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s += longint'(elem(a[r*n+k], sg)) *
                         longint'(elem(b[k*n+c], sg));
                q.push_back(s);
            end
        end
    endfunction

    task automatic fill4(output int arr[64], input int v0, input int v1,
                         input int v2, input int v3);
        arr = '{default: 0};
        arr[0] = v0;
        arr[1] = v1;
        arr[2] = v2;
        arr[3] = v3;
    endtask

    task automatic load(input int s, input int n, input int a[64],
                        input int b[64], input bit gaps);
        sel = s;
        for (int m = 0; m < n*n; m++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    vld = 1'b0;
                    da  = 8'($urandom);
                    db  = 8'($urandom);
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            vld = 1'b1;
            da  = 8'(a[m]);
            db  = 8'(b[m]);
            if (m == 0) check("in_ready_load", get_ir(s), 1);
            @(posedge clk);
            @(negedge clk);
        end
        vld = 1'b0;
    endtask

    task automatic collect(input int s, input int n, input int mode,
                           input longint exp[$]);
        int     got;
        int     t;
        int     stall;
        int     last_t;
        bit     first;
        bit     held;
        longint held_d;
        int     ov;
        int     ol;
        longint od;
        got    = 0;
        t      = 0;
        stall  = 0;
        last_t = -1;
        first  = 1'b1;
        held   = 1'b0;
        held_d = 0;
        check("busy_compute", get_busy(s), 1);
        check("in_ready_compute", get_ir(s), 0);
        while (got < n*n && t < 4000) begin
            ov = get_ov(s);
            od = get_od(s);
            ol = get_ol(s);
            if (held) begin
                check("hold_valid", ov, 1);
                check("hold_data", od, held_d);
            end
            if (ov != 0 && first) begin
                check("latency", t, n);
                first = 1'b0;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (ov != 0) && (stall >= 5);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (ov != 0 && rdy) begin
                check($sformatf("data[%0d]", got), od, exp[got]);
                check("last", ol, (got == n*n-1) ? 1 : 0);
                if (mode == 0 && last_t >= 0)
                    check("interval", t - last_t, n + 1);
                last_t = t;
                got++;
                stall = 0;
            end else if (ov != 0) begin
                stall++;
            end
            held   = (ov != 0) && !rdy;
            held_d = od;
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        rdy = 1'b0;
        check("count", got, n*n);
        check("idle_valid", get_ov(s), 0);
        check("idle_in_ready", get_ir(s), 1);
    endtask

    task automatic run_pair(input int s, input int n, input int a[64],
                            input int b[64], input int mode, input bit gaps,
                            input longint exp[$]);
        load(s, n, a, b, gaps);
        collect(s, n, mode, exp);
    endtask

    task automatic rand_pair(input int s, input int n, input bit sg,
                             input int mode);
        int     a[64];
        int     b[64];
        longint q[$];
        for (int m = 0; m < 64; m++) begin
            a[m] = int'($urandom_range(0, 255));
            b[m] = int'($urandom_range(0, 255));
        end
        ref_mul(n, sg, a, b, q);
        run_pair(s, n, a, b, mode, 1'b1, q);
    endtask

    task automatic check_reset_outputs(input int s, input string tag);
        check({tag, "_valid"}, get_ov(s), 0);
        check({tag, "_data"}, get_od(s), 0);
        check({tag, "_last"}, get_ol(s), 0);
        check({tag, "_busy"}, get_busy(s), 0);
        check({tag, "_in_ready"}, get_ir(s), 1);
    endtask

    initial begin
        int     ta[64];
        int     tb2[64];
        int     ra[64];
        int     rb[64];
        longint eq[$];

        #12;
        check_reset_outputs(0, "rst0");
        check_reset_outputs(2, "rst2");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        fill4(ta, 1, 2, 4, 8);
        fill4(tb2, 1, 3, 5, 11);
        eq = {11, 25, 44, 100};
        run_pair(0, 2, ta, tb2, 0, 1'b0, eq);

        fill4(ra, -1, 2, 3, -4);
        fill4(rb, 5, -6, 7, 8);
        run_pair(1, 2, ra, rb, 0, 1'b0, {9, 22, -13, -50});

        ra = '{default: 0};
        rb = '{default: 0};
        eq = {};
        for (int m = 0; m < 16; m++) begin
            ra[m] = (m / 4 == m % 4) ? 1 : 0;
            rb[m] = m + 1;
            eq.push_back(m + 1);
        end
        run_pair(2, 4, ra, rb, 0, 1'b0, eq);

        fill4(ra, 255, 255, 255, 255);
        run_pair(0, 2, ra, ra, 0, 1'b0, {130050, 130050, 130050, 130050});

        run_pair(0, 2, ta, tb2, 1, 1'b1, {11, 25, 44, 100});

        sel = 0;
        vld = 1'b1;
        da  = 8'd77;
        db  = 8'd99;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        abt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abt = 1'b0;
        vld = 1'b0;
        check("abort_load_in_ready", get_ir(0), 1);
        run_pair(0, 2, ta, tb2, 0, 1'b1, {11, 25, 44, 100});

        load(0, 2, ta, tb2, 1'b0);
        for (int c = 0; c < 50 && get_ov(0) == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_wait_out", get_ov(0), 1);
        abt = 1'b1;
        rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abt = 1'b0;
        rdy = 1'b0;
        check("abort_out_valid", get_ov(0), 0);
        check("abort_out_in_ready", get_ir(0), 1);
        check("abort_out_busy", get_busy(0), 0);
        run_pair(0, 2, ta, tb2, 2, 1'b1, {11, 25, 44, 100});

        for (int m = 0; m < 64; m++) begin
            ra[m] = int'($urandom_range(0, 255));
            rb[m] = int'($urandom_range(0, 255));
        end
        load(2, 4, ra, rb, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs(2, "midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rand_pair(2, 4, 1'b0, 0);

        for (int r = 0; r < 4; r++) begin
            rand_pair(0, 2, 1'b0, 2);
            rand_pair(1, 2, 1'b1, 2);
            rand_pair(2, 4, 1'b0, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
